// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: state encoding, wait-counter width and default window base for mem_responder.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
package mem_responder_pkg;
  localparam int DEF_WORD_SIZE = `WORD_SIZE;
  localparam int CNT_W = 4;
  localparam logic [DEF_WORD_SIZE-1:0] DEF_BASE_ADDR = DEF_WORD_SIZE'('h8000);
  typedef enum logic [2:0] {ST_IDLE, ST_RWAIT, ST_RDATA, ST_WWAIT, ST_WDONE} state_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU-side request/response signals of the memory responder.
interface mem_responder_if
  import mem_responder_pkg::*;
#(parameter int WORD_SIZE = DEF_WORD_SIZE);
  logic [WORD_SIZE-1:0] addr_bus;
  logic read_en, write_en, ready, bus_err;
  modport master (output addr_bus, read_en, write_en, input ready, bus_err);
  modport slave (input addr_bus, read_en, write_en, output ready, bus_err);
endinterface

// File: rtl/mem_responder_array.sv
// mem_responder_array: DEPTH x 8 storage, synchronous write port, registered read; contents never reset.
module mem_responder_array #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    data_q
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) data_q <= mem[raddr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: windowed byte-wide bus target with programmable wait states and a tristated read bus.
// Define MEM_ROM_PROTECT_EN to make the lowest ROM_SIZE bytes write-protected.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR = WORD_SIZE'(DEF_BASE_ADDR),
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 2
`ifdef MEM_ROM_PROTECT_EN
  , parameter int ROM_SIZE = 16
`endif
) (
  input logic clk,
  input logic reset,
  mem_responder_if.slave bus,
  inout wire [7:0] ext_data_bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  localparam bit NO_WAIT = WAIT_STATES == 0;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [AW-1:0] off_in, off_q, waddr, raddr;
  logic [7:0] wd_q, wdata, data_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic sel, start, conflict, err_seen, err_q, err_n, we, re, prot;

  assign sel = {1'b0, bus.addr_bus} >= {1'b0, BASE_ADDR} &&
               {1'b0, bus.addr_bus} < (WORD_SIZE+1)'(BASE_ADDR + DEPTH);
  assign off_in = AW'(bus.addr_bus - BASE_ADDR);

`ifdef MEM_ROM_PROTECT_EN
  logic rom_q;
  // protection is decided from the live address in IDLE and remembered for the rest of the access
  assign prot = state == ST_IDLE ? {1'b0, off_in} < (AW+1)'(ROM_SIZE) : rom_q;
  always_ff @(posedge clk)
    if (start) rom_q <= prot;
`else
  assign prot = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    start = 1'b0;
    conflict = 1'b0;
    we = 1'b0;
    re = 1'b0;
    waddr = off_q;
    raddr = off_q;
    wdata = wd_q;
    case (state)
      ST_IDLE: begin
        conflict = sel && bus.read_en && bus.write_en;
        start = sel && (bus.read_en ^ bus.write_en);
        cnt_n = CNT_INIT;
        raddr = off_in;
        waddr = off_in;
        wdata = ext_data_bus;
        re = start && bus.read_en && NO_WAIT;
        we = start && bus.write_en && NO_WAIT && !prot;
        state_n = !start ? ST_IDLE :
                  bus.read_en ? (NO_WAIT ? ST_RDATA : ST_RWAIT) : (NO_WAIT ? ST_WDONE : ST_WWAIT);
      end
      ST_RWAIT: begin
        re = bus.read_en && cnt == '0;
        cnt_n = cnt - 1'b1;
        state_n = !bus.read_en ? ST_IDLE : cnt == '0 ? ST_RDATA : ST_RWAIT;
      end
      ST_WWAIT: begin
        we = bus.write_en && cnt == '0 && !prot;
        cnt_n = cnt - 1'b1;
        state_n = !bus.write_en ? ST_IDLE : cnt == '0 ? ST_WDONE : ST_WWAIT;
      end
      ST_RDATA: state_n = (!bus.read_en || bus.addr_bus != addr_q) ? ST_IDLE : ST_RDATA;
      ST_WDONE: state_n = bus.write_en ? ST_WDONE : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // a held conflicting request reports once, not every cycle
    err_n = (conflict && !err_seen) || (prot && state_n == ST_WDONE && state != ST_WDONE);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      err_q <= 1'b0;
      err_seen <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      err_q <= err_n;
      err_seen <= conflict;
    end

  always_ff @(posedge clk)
    if (start) begin
      off_q <= off_in;
      wd_q <= ext_data_bus;
      addr_q <= bus.addr_bus;
    end

  mem_responder_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr), .data_q(data_q)
  );

  assign bus.ready = state == ST_RDATA || state == ST_WDONE;
  assign bus.bus_err = err_q;
  assign ext_data_bus = (state == ST_RDATA && bus.read_en) ? data_q : 8'bz;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Byte-wide memory-side bus responder: the target end of the CPU's external memory bus.
- Decodes the CPU's addr_bus against a base/size window.
- Services single-byte read_en/write_en requests from an internal RAM, with a programmable wait-state count.
- Drives ext_data_bus only while returning read data, and signals completion on a ready strobe for the CPU's future wait-state support.

Parameters:
- WORD_SIZE, `WORD_SIZE (16): address bus width.
- BASE_ADDR, 16'h8000: first decoded address.
- DEPTH, 256: bytes of storage; power of two, at least 2.
- WAIT_STATES, 2: extra cycles per access, range 0..15.
- ROM_SIZE, 16: write-protected low region; used only with MEM_ROM_PROTECT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr_bus  input  WORD_SIZE  byte address from the CPU.
- ext_data_bus  inout  8  shared data bus; driven by this block only in RDATA.
- read_en  input  1  CPU read request, level, held until ready.
- write_en  input  1  CPU write request, level; data valid on ext_data_bus while high.
- ready  output  1  access complete (read data valid / write committed).
- bus_err  output  1  one-cycle pulse on an illegal request.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values:
  - state IDLE, wait counter 0, ready 0, bus_err 0.
  - ext_data_bus released to all-z.
  - RAM contents are not cleared.
  - Reset mid-access aborts the access; a pending write is dropped.
- Decode:
  - sel = (addr_bus >= BASE_ADDR) && (addr_bus < BASE_ADDR+DEPTH).
  - offset = addr_bus - BASE_ADDR, truncated to clog2(DEPTH) bits.
  - X or z on addr_bus means not selected.
- States: IDLE, RWAIT, RDATA, WWAIT, WDONE.
- IDLE:
  - sel & read_en & !write_en: latch offset.
    - WAIT_STATES==0: load data_q from RAM, go to RDATA.
    - Otherwise: cnt=WAIT_STATES-1, go to RWAIT.
  - sel & write_en & !read_en: latch offset and ext_data_bus.
    - WAIT_STATES==0: commit, go to WDONE.
    - Otherwise: cnt=WAIT_STATES-1, go to WWAIT.
  - sel & read_en & write_en: bus_err=1 for one cycle, no access, stay in IDLE.
  - Not selected: ignore, bus remains z.
- RWAIT / WWAIT:
  - cnt!=0: decrement.
  - cnt==0: RWAIT loads data_q and goes to RDATA; WWAIT writes RAM[offset] and goes to WDONE.
  - Request deasserted during the wait: go to IDLE with no RAM write and no ready.
- RDATA:
  - ready=1, ext_data_bus = data_q (combinational: state==RDATA && read_en).
  - Stay while read_en is held and addr_bus is unchanged.
  - read_en low: release the bus the same cycle, go to IDLE.
  - addr_bus changes while read_en is high: go to IDLE, which re-evaluates next cycle as a new access.
- WDONE:
  - ready=1; stay until write_en falls, then go to IDLE.
  - A single commit per request; holding write_en does not rewrite.
- Latency: data valid / write committed after WAIT_STATES+1 rising edges from the first edge the request is seen in IDLE.
- Write data is sampled only in IDLE; changes on ext_data_bus during WWAIT are ignored.
- Back-to-back accesses: at least one IDLE cycle (request low) between accesses.
- Never drive ext_data_bus during a write or in any state other than RDATA.

Optional Feature:
- MEM_ROM_PROTECT_EN defined:
  - Writes with offset < ROM_SIZE complete the full handshake (wait states, WDONE, ready) but do not modify RAM.
  - bus_err pulses one cycle on entry to WDONE.
- MEM_ROM_PROTECT_EN undefined: all offsets writable, ROM_SIZE ignored, no protection logic.

Decomposition:
- Shared header mem_defs.vh (alongside sizes.vh and signals.vh):
  - state encodings MEM_ST_IDLE/RWAIT/RDATA/WWAIT/WDONE (3-bit).
  - wait counter width 4.
  - default BASE_ADDR.
- Sub-module mem_array:
  - DEPTH x 8 storage, synchronous write port (we, waddr, wdata).
  - Registered read into data_q; no reset on contents.
- mem_responder holds the FSM, decode, counter, and tristate.

Test Plan:
- Reset with WAIT_STATES=2: assert reset mid-RWAIT -> ready=0 and ext_data_bus z immediately (async); after release, state is IDLE and a previously written byte is still readable.
- Write then read, WAIT_STATES=2: write 8'hA5 to 16'h8010 -> ready at edge 3; release; read 16'h8010 -> ext_data_bus=8'hA5 with ready=1 at edge 3; read_en low -> bus z the same cycle.
- WAIT_STATES=0: write 8'h3C to 16'h80FF (top of window) -> ready after 1 edge; read back 8'h3C after 1 edge. Accesses to 16'h8100 and 16'h7FFF -> no ready, bus stays z.
- Abort: start a write of 8'h11 to 16'h8020 over a prior 8'h77, drop write_en in WWAIT -> no ready; read 16'h8020 returns 8'h77.
- Conflict: read_en=write_en=1 at 16'h8000 -> bus_err high for exactly 1 cycle, no ready, RAM unchanged, bus z.
- MEM_ROM_PROTECT_EN defined, ROM_SIZE=16: write 8'hFF to 16'h8005 -> ready=1 and bus_err pulse; read returns the old value. Write to 16'h8010 commits normally with no bus_err.
